regfile_dump_reader: RTL and testbench

- Debug/trace initiator that drives one read port of the 32x32 integer register file.
- On a start pulse, walks register indices 0..NUM_REGS-1 and captures each word from the register file's combinational read data.
- Streams each word out on a valid/ready interface with its index.
- Sits beside the core datapath, sharing a read-address mux with decode; the read port is owned only while busy=1.

---
 rtl/regfile_dump_reader.sv | 123 ++++++++++++
 tb/tb_regfile_dump_reader.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// Walks register file read port over indices 0..NUM_REGS-1 and streams each word out with its index.
// Optional DUMP_CHECKSUM_EN appends one XOR-of-all-words beat after the register beats.
module regfile_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx;
    logic              at_last;
    logic              hs;
    logic              walk_end;

    assign rf_addr = idx;
    assign at_last = (idx == LAST_IDX);
    assign hs      = out_valid && out_ready;

`ifdef DUMP_CHECKSUM_EN
    logic              csum_beat;
    logic [DATA_W-1:0] csum;
    // The walk only ends once the trailing checksum beat has been accepted.
    assign walk_end = csum_beat;
`else
    assign walk_end = at_last;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = S_LOAD;
            S_LOAD: state_nxt = S_WAIT;
            S_WAIT: if (hs) state_nxt = walk_end ? S_DONE : S_LOAD;
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            csum_beat <= 1'b0;
            csum      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    idx  <= '0;
                    busy <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                    csum_beat <= 1'b0;
                    csum      <= '0;
`endif
                end
                S_LOAD: begin
                    out_valid <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                    if (csum_beat) begin
                        out_addr <= '0;
                        out_data <= csum;
                        out_last <= 1'b1;
                    end else begin
                        out_addr <= idx;
                        out_data <= rf_data;
                        out_last <= 1'b0;
                        csum     <= csum ^ rf_data;
                    end
`else
                    out_addr <= idx;
                    out_data <= rf_data;
                    out_last <= at_last;
`endif
                end
                S_WAIT: if (hs) begin
                    out_valid <= 1'b0;
                    // idx parks at the last index; it never wraps back to 0 mid-walk.
                    if (!at_last) idx <= idx + 1'b1;
`ifdef DUMP_CHECKSUM_EN
                    else          csum_beat <= 1'b1;
`endif
                end
                S_DONE: begin
                    busy <= 1'b0;
                    idx  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader; the bench itself models the register file.
// Build with +define+DUMP_CHECKSUM_EN to exercise the trailing checksum beat.
module tb_regfile_dump_reader;

    localparam int N  = 32;
    localparam int AW = 5;
    localparam int DW = 32;
`ifdef DUMP_CHECKSUM_EN
    localparam int NB    = N + 1;
    localparam bit CSUM  = 1'b1;
    localparam int DLAT  = 2*N + 4;
`else
    localparam int NB    = N;
    localparam bit CSUM  = 1'b0;
    localparam int DLAT  = 2*N + 2;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          out_last;

    logic [DW-1:0] rf [N];
    assign rf_data = rf[rf_addr];

    regfile_dump_reader #(.NUM_REGS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .rf_addr(rf_addr), .rf_data(rf_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int start_cyc;

    // Accepted beats and done pulses, recorded away from the active edge.
    logic [AW-1:0] baddr [$];
    logic [DW-1:0] bdata [$];
    logic          blast [$];
    int            bcyc  [$];
    int            done_cnt = 0;
    int            done_cyc = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                baddr.push_back(out_addr);
                bdata.push_back(out_data);
                blast.push_back(out_last);
                bcyc.push_back(cyc);
            end
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
        end
    end

    task automatic preload();
        for (int k = 0; k < N; k++) rf[k] = 32'h1000_0000 + k;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Returns one cycle after the done pulse, or with to=1 after the budget expires.
    task automatic wait_done(input int d0, output bit to);
        to = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (done_cnt > d0) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < N; k++) rf[k] = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_checks++; if ({out_addr, out_data, out_last, rf_addr} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: addr %h data %h last %b rf_addr %h want all 0",
                               out_addr, out_data, out_last, rf_addr);
        end
        reset = 1'b0;
    endtask

    task automatic test_full_dump();
        int b0, d0, bad;
        bit to;
        preload();
        out_ready = 1'b1;
        b0 = baddr.size(); d0 = done_cnt;
        pulse_start();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy_high: got %b want 1", busy); end
        wait_done(d0, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL full_done_timeout: got timeout want done"); end
        n_checks++; if (baddr.size() - b0 !== NB) begin
            n_fail++; $display("FAIL full_beat_count: got %0d want %0d", baddr.size() - b0, NB);
        end
        bad = 0;
        if (baddr.size() - b0 >= N)
            for (int k = 0; k < N; k++)
                if (baddr[b0+k] !== AW'(k) || bdata[b0+k] !== 32'h1000_0000 + k ||
                    blast[b0+k] !== (!CSUM && k == N-1)) bad++;
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL full_beat_content: got %0d bad beats want 0", bad); end
        if (baddr.size() - b0 >= 2) begin
            n_checks++; if (bcyc[b0] - start_cyc !== 2) begin
                n_fail++; $display("FAIL full_first_valid: got %0d cycles want 2", bcyc[b0] - start_cyc);
            end
            n_checks++; if (bcyc[b0+1] - bcyc[b0] !== 2) begin
                n_fail++; $display("FAIL full_beat_spacing: got %0d want 2", bcyc[b0+1] - bcyc[b0]);
            end
        end
        // Latency counts the start cycle and the done cycle inclusively.
        n_checks++; if (done_cyc - start_cyc + 1 !== DLAT) begin
            n_fail++; $display("FAIL full_done_latency: got %0d want %0d", done_cyc - start_cyc + 1, DLAT);
        end
        n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL full_done_count: got %0d want 1", done_cnt - d0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_low: got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        int b0, d0, bad;
        bit to;
        preload();
        out_ready = 1'b1;
        b0 = baddr.size(); d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 40 && !(out_valid && out_addr == 3); i++) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_addr !== 5'd3 || out_data !== 32'h1000_0003 || rf_addr !== 5'd3) begin
                n_fail++; $display("FAIL bp_hold: cycle %0d got v=%b addr=%h data=%h rf_addr=%h want 1/03/10000003/03",
                                   c, out_valid, out_addr, out_data, rf_addr);
            end
        end
        out_ready = 1'b1;
        wait_done(d0, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL bp_done_timeout: got timeout want done"); end
        n_checks++; if (baddr.size() - b0 !== NB) begin
            n_fail++; $display("FAIL bp_beat_count: got %0d want %0d", baddr.size() - b0, NB);
        end
        bad = 0;
        if (baddr.size() - b0 >= N)
            for (int k = 0; k < N; k++) if (baddr[b0+k] !== AW'(k)) bad++;
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_sequence: got %0d out-of-order beats want 0", bad); end
    endtask

    task automatic test_start_while_busy();
        int b0, d0, bad;
        bit to;
        preload();
        out_ready = 1'b1;
        b0 = baddr.size(); d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 40 && baddr.size() - b0 < 4; i++) begin @(posedge clk); #1; end
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        for (int i = 0; i < 60 && baddr.size() - b0 < 20; i++) begin @(posedge clk); #1; end
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        wait_done(d0, to);
        repeat (10) @(posedge clk);
        #1;
        n_checks++; if (to) begin n_fail++; $display("FAIL swb_done_timeout: got timeout want done"); end
        n_checks++; if (baddr.size() - b0 !== NB) begin
            n_fail++; $display("FAIL swb_beat_count: got %0d want %0d", baddr.size() - b0, NB);
        end
        n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL swb_done_count: got %0d want 1", done_cnt - d0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL swb_busy_after: got %b want 0", busy); end
        bad = 0;
        if (baddr.size() - b0 >= N)
            for (int k = 0; k < N; k++) if (baddr[b0+k] !== AW'(k)) bad++;
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL swb_sequence: got %0d bad beats want 0", bad); end
    endtask

    // LOAD for idx k occupies cycle start+1+2k with ready held high.
    task automatic test_write_race();
        int b0, d0;
        bit to;
        for (int pass = 0; pass < 2; pass++) begin
            preload();
            rf[10] = 32'h0A0A_0A0A;
            out_ready = 1'b1;
            b0 = baddr.size(); d0 = done_cnt;
            pulse_start();
            for (int i = 0; i < 40 && cyc < start_cyc + 22 - pass; i++) begin @(posedge clk); #1; end
            rf[10] = 32'hDEAD_BEEF;
            wait_done(d0, to);
            n_checks++;
            if (to || baddr.size() - b0 < 11) begin
                n_fail++; $display("FAIL race_%0d_run: got %0d beats want %0d", pass, baddr.size() - b0, NB);
            end else if (baddr[b0+10] !== 5'd10 ||
                         bdata[b0+10] !== (pass == 0 ? 32'h0A0A_0A0A : 32'hDEAD_BEEF)) begin
                n_fail++; $display("FAIL race_%0d_beat10: got addr %h data %h want 0a/%h", pass,
                                   baddr[b0+10], bdata[b0+10], (pass == 0 ? 32'h0A0A_0A0A : 32'hDEAD_BEEF));
            end
        end
    endtask

    task automatic test_reset_mid_dump();
        int b0, d0;
        bit to;
        preload();
        out_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 40 && !(out_valid && out_addr == 7); i++) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        @(negedge clk); #1;
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, out_valid, out_last} !== 4'b0 || out_addr !== '0 || out_data !== '0 || rf_addr !== '0) begin
            n_fail++; $display("FAIL midreset_outputs: got busy=%b done=%b v=%b last=%b addr=%h data=%h rf_addr=%h want all 0",
                               busy, done, out_valid, out_last, out_addr, out_data, rf_addr);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++; if (done_cnt !== d0) begin n_fail++; $display("FAIL midreset_no_done: got %0d pulses want 0", done_cnt - d0); end
        rf[0] = 32'h0BAD_0000;
        out_ready = 1'b1;
        b0 = baddr.size(); d0 = done_cnt;
        pulse_start();
        wait_done(d0, to);
        n_checks++;
        if (to || baddr.size() - b0 !== NB) begin
            n_fail++; $display("FAIL midreset_restart_count: got %0d beats want %0d", baddr.size() - b0, NB);
        end else if (baddr[b0] !== 5'd0 || bdata[b0] !== 32'h0BAD_0000) begin
            n_fail++; $display("FAIL midreset_restart_first: got addr %h data %h want 00/0bad0000", baddr[b0], bdata[b0]);
        end
    endtask

`ifdef DUMP_CHECKSUM_EN
    task automatic test_checksum();
        int b0, d0, bad;
        bit to;
        for (int k = 0; k < N; k++) rf[k] = '0;
        rf[5] = 32'hA5A5_0000;
        rf[9] = 32'h0000_5A5A;
        out_ready = 1'b1;
        b0 = baddr.size(); d0 = done_cnt;
        pulse_start();
        wait_done(d0, to);
        n_checks++;
        if (to || baddr.size() - b0 !== N + 1) begin
            n_fail++; $display("FAIL csum_beat_count: got %0d want %0d", baddr.size() - b0, N + 1);
        end else begin
            n_checks++;
            if (bdata[b0+N] !== 32'hA5A5_5A5A || baddr[b0+N] !== 5'd0 || blast[b0+N] !== 1'b1) begin
                n_fail++; $display("FAIL csum_beat: got data %h addr %h last %b want a5a55a5a/00/1",
                                   bdata[b0+N], baddr[b0+N], blast[b0+N]);
            end
            bad = 0;
            for (int k = 0; k < N; k++) if (blast[b0+k] !== 1'b0) bad++;
            n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL csum_reg_last: got %0d beats with last want 0", bad); end
        end
        n_checks++; if (done_cyc - start_cyc + 1 !== 2*N + 4) begin
            n_fail++; $display("FAIL csum_done_latency: got %0d want %0d", done_cyc - start_cyc + 1, 2*N + 4);
        end
    endtask
`endif

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_full_dump();
        test_backpressure();
        test_start_while_busy();
        test_write_race();
        test_reset_mid_dump();
`ifdef DUMP_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
